// File: rtl/serial_operand_feeder.sv
`timescale 1ns/1ps
// serial_operand_feeder
//   Accepts parallel operand pairs (A, B) and streams them LSB first as bit
//   pairs to a bit-serial adder. It holds one active pair plus one buffered
//   pair, so back-to-back operands stream without gaps.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   up_vld  : parallel pair valid
//   up_rdy  : feeder can accept a pair this cycle (from registered state only)
//   up_a    : operand A, parallel, WIDTH bits
//   up_b    : operand B, parallel, WIDTH bits
//   stall   : suppress bit emission this cycle (bubble)
//   vld     : serial bit pair valid
//   a, b    : serial bits of A and B, LSB first
//   last    : current bit pair is the operand MSB
module serial_operand_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             stall,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  localparam int unsigned   CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic             busy_q,    busy_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] sh_a_q,    sh_a_d;
  logic [WIDTH-1:0] sh_b_q,    sh_b_d;
  logic             buf_vld_q, buf_vld_d;
  logic [WIDTH-1:0] buf_a_q,   buf_a_d;
  logic [WIDTH-1:0] buf_b_q,   buf_b_d;

  logic accept;
  logic slot_free;

  // Serial outputs; the active operands are shifted so bit cnt sits at bit 0.
  always_comb begin
    up_rdy = !rst && !buf_vld_q;
    vld    = busy_q && !stall && !rst;
    last   = vld && (cnt_q == CNT_MAX);
    a      = vld && sh_a_q[0];
    b      = vld && sh_b_q[0];
  end

  // Active slot frees when idle or when its MSB is actually emitted this cycle.
  always_comb begin
    accept    = up_vld && up_rdy;
    slot_free = !busy_q || last;
  end

  // Next-state for the active and buffered pairs.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    buf_vld_d = buf_vld_q;
    buf_a_d   = buf_a_q;
    buf_b_d   = buf_b_q;

    // Advance only on emitted bits; a stalled cycle leaves everything frozen.
    if (vld) begin
      cnt_d  = cnt_q + CW'(1);
      sh_a_d = sh_a_q >> 1;
      sh_b_d = sh_b_q >> 1;
    end

    if (slot_free) begin
      if (buf_vld_q) begin
        busy_d    = 1'b1;
        cnt_d     = '0;
        sh_a_d    = buf_a_q;
        sh_b_d    = buf_b_q;
        buf_vld_d = accept;
        if (accept) begin
          buf_a_d = up_a;
          buf_b_d = up_b;
        end
      end else if (accept) begin
        // Bypass straight into the active slot.
        busy_d = 1'b1;
        cnt_d  = '0;
        sh_a_d = up_a;
        sh_b_d = up_b;
      end else begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (accept) begin
      buf_vld_d = 1'b1;
      buf_a_d   = up_a;
      buf_b_d   = up_b;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      buf_vld_q <= 1'b0;
      buf_a_q   <= '0;
      buf_b_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      buf_vld_q <= buf_vld_d;
      buf_a_q   <= buf_a_d;
      buf_b_q   <= buf_b_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
`timescale 1ns/1ps
// Directed bench for serial_operand_feeder (WIDTH=8).
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_vld = 1'b0;
  logic       up_rdy;
  logic [7:0] up_a = '0;
  logic [7:0] up_b = '0;
  logic       stall = 1'b0;
  logic       vld;
  logic       a;
  logic       b;
  logic       last;

  int tests = 0;
  int fails = 0;

  logic [7:0] pa [4];
  logic [7:0] pb [4];

  serial_operand_feeder #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .up_vld (up_vld),
    .up_rdy (up_rdy),
    .up_a   (up_a),
    .up_b   (up_b),
    .stall  (stall),
    .vld    (vld),
    .a      (a),
    .b      (b),
    .last   (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".vld"},  8'(vld),  8'h00);
    check({tag, ".a"},    8'(a),    8'h00);
    check({tag, ".b"},    8'(b),    8'h00);
    check({tag, ".last"}, 8'(last), 8'h00);
  endtask

  // Feeds pa/pb[0..npairs-1] from an idle feeder and checks ncyc cycles.
  // smask bit c = stall during cycle c (cycle 0 is the first accept cycle).
  // Data is randomised whenever the pair must not be accepted.
  task automatic run_stream(input int npairs, input int ncyc,
                            input logic [31:0] smask, input int expbits);
    int         k = 0;
    int         j = 0;
    int         outst = 0;
    int         p;
    int         i;
    logic       cy = 1'b0;
    logic [7:0] s = '0;
    logic [7:0] sum_exp;
    logic       acc;
    logic       emit_last;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      stall  = smask[c];
      up_vld = (k < npairs);
      if (k < npairs && outst < 2) begin
        up_a = pa[k];
        up_b = pb[k];
      end else begin
        up_a = 8'($urandom);
        up_b = 8'($urandom);
      end
      #1;
      check("up_rdy", 8'(up_rdy), 8'(outst < 2));
      emit_last = 1'b0;
      if (smask[c] || outst == 0) begin
        check_idle("bubble");
      end else begin
        p = j / 8;
        i = j % 8;
        check("vld",  8'(vld),  8'h01);
        check("a",    8'(a),    8'(pa[p][i]));
        check("b",    8'(b),    8'(pb[p][i]));
        check("last", 8'(last), 8'(i == 7));
        s[i] = a ^ b ^ cy;
        cy   = (a & b) | (a & cy) | (b & cy);
        if (i == 7) begin
          sum_exp = pa[p] + pb[p];
          check("sum", s, sum_exp);
          cy        = 1'b0;
          emit_last = 1'b1;
        end
        j++;
      end
      acc = up_vld && (outst < 2);
      if (acc) k++;
      outst = outst + int'(acc) - int'(emit_last);
    end
    check("nbits", 8'(j), 8'(expbits));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check_idle("rst");
    check("rst.up_rdy", 8'(up_rdy), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst.up_rdy", 8'(up_rdy), 8'h01);
    check("post_rst.vld", 8'(vld), 8'h00);

    // Idle accept, 0x5A + 0x3C = 0x96
    pa[0] = 8'h5A; pb[0] = 8'h3C;
    run_stream(1, 11, 32'h0, 8);

    // Back-to-back with up_vld held; random data while up_rdy is low
    pa[0] = 8'hFF; pb[0] = 8'h01;
    pa[1] = 8'h80; pb[1] = 8'h80;
    pa[2] = 8'h00; pb[2] = 8'h00;
    run_stream(3, 28, 32'h0, 24);

    // Two-cycle stall on bit 3
    pa[0] = 8'h5A; pb[0] = 8'h3C;
    run_stream(1, 13, 32'h0000_0030, 8);

    // Stall on the MSB with a buffered pair waiting
    pa[0] = 8'h5A; pb[0] = 8'h3C;
    pa[1] = 8'h11; pb[1] = 8'h22;
    run_stream(2, 20, 32'h0000_0100, 16);

    // Reset mid-stream at bit 4 with the buffer full
    pa[0] = 8'h5A; pb[0] = 8'h3C;
    pa[1] = 8'hA5; pb[1] = 8'hC3;
    run_stream(2, 5, 32'h0, 4);
    @(negedge clk);
    up_vld = 1'b0;
    stall  = 1'b0;
    #1;
    check("bit4.vld", 8'(vld), 8'h01);
    check("bit4.a",   8'(a),   8'h01);
    check("bit4.b",   8'(b),   8'h01);
    check("bit4.up_rdy", 8'(up_rdy), 8'h00);
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    check("mid_rst.up_rdy", 8'(up_rdy), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel.up_rdy", 8'(up_rdy), 8'h01);
    check_idle("rel");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      check("rel_idle.up_rdy", 8'(up_rdy), 8'h01);
      check_idle("rel_idle");
    end

    // Fresh pair after reset: 0xC3 + 0x5A = 0x1D (mod 256)
    pa[0] = 8'hC3; pb[0] = 8'h5A;
    run_stream(1, 11, 32'h0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range WIDTH >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: up_vld  input  1  parallel operand pair valid.
REQ-005 Port: up_rdy  output  1  feeder can accept a pair this cycle.
REQ-006 Port: up_a  input  WIDTH  operand A, parallel.
REQ-007 Port: up_b  input  WIDTH  operand B, parallel.
REQ-008 Port: stall  input  1  suppress bit emission this cycle (bubble insertion).
REQ-009 Port: vld  output  1  serial bit pair valid, to the serial adder.
REQ-010 Port: a  output  1  serial bit of A, LSB first.
REQ-011 Port: b  output  1  serial bit of B, LSB first.
REQ-012 Port: last  output  1  current bit pair is the MSB of the operands.

Function
REQ-013 The block SHALL hold one active pair (shift registers, bit counter cnt 0..WIDTH-1, busy flag) and one buffered pair (buf_vld, buf_a, buf_b).
REQ-014 The block SHALL drive up_rdy = !rst & !buf_vld, combinationally from registered state; it SHALL NOT depend on up_vld.
REQ-015 A pair SHALL be accepted on a rising edge where up_vld & up_rdy.
REQ-016 Active slot free at an edge: !busy, or busy & vld & last.
REQ-017 At an edge with active slot free and buf_vld=1: buffer SHALL move to active (cnt=0, busy=1); any pair accepted at the same edge SHALL enter the buffer.
REQ-018 At an edge with active slot free and buf_vld=0: an accepted pair SHALL load directly into active (bypass); otherwise busy SHALL clear.
REQ-019 At an edge with active slot not free: an accepted pair SHALL enter the buffer.
REQ-020 The block SHALL drive vld = busy & !stall, combinationally; a, b SHALL be bit cnt of the active A, B; last = vld & (cnt == WIDTH-1).
REQ-021 When vld=0, a, b and last SHALL be driven 0.
REQ-022 cnt SHALL advance only at edges where vld=1; stall SHALL freeze cnt and operand bits with no loss or duplication.
REQ-023 Latency: pair accepted at edge N into an idle feeder SHALL present bit 0 with vld=1 during cycle N+1 (if stall=0).
REQ-024 Throughput: with up_vld held high and stall=0, vld SHALL stay 1 continuously, one pair every WIDTH cycles, no gap between last of one pair and bit 0 of the next.
REQ-025 stall asserted during the last bit SHALL delay the active/buffer hand-off until the edge where last is actually emitted.
REQ-026 Downstream contract: the vld/a/b/last stream SHALL satisfy the serial adder rule that last is only meaningful with vld=1 and ends an addition.

Reset
REQ-027 While rst=1: busy=0, buf_vld=0, cnt=0; vld, a, b, last SHALL be 0 and up_rdy SHALL be 0, immediately (asynchronously).
REQ-028 After rst deasserts, up_rdy SHALL be 1 and the first acceptance SHALL follow REQ-023.
REQ-029 rst mid-operation SHALL discard both active and buffered pairs; no partial stream SHALL resume.

Verification (WIDTH=8)
REQ-030 Idle accept: up_a=0x5A, up_b=0x3C, stall=0 -> next 8 cycles vld=1, a=0,1,0,1,1,0,1,0, b=0,0,1,1,1,1,0,0, last=1 only on 8th; feeding an adder yields 0x96.
REQ-031 Back-to-back: pairs (0xFF,0x01), (0x80,0x80), (0x00,0x00) with up_vld held -> 24 contiguous vld cycles, last at cycles 8/16/24, up_rdy low while buffer full.
REQ-032 Stall: during pair (0x5A,0x3C) assert stall on bit 3 for 2 cycles -> vld=0, a=b=last=0 for those cycles; remaining bits resume at bit 3 unchanged.
REQ-033 Stall on last: stall high during MSB cycle with buffered pair -> last and buffer hand-off both delayed 1 cycle; next pair bit 0 follows immediately.
REQ-034 Reset mid-stream: assert rst at bit 4 of a pair with buffer full -> outputs 0 and up_rdy 0 immediately; after release up_rdy=1, vld=0 until new pair.
REQ-035 Handshake: up_vld=1 while up_rdy=0 for 5 cycles with changing data -> no acceptance; pair accepted only on the first up_rdy=1 edge.
